// File: rtl/delay_timer.sv
// delay_timer: runtime-programmable cycle delay / timer.
//
// A start pulse latches the delay length N (0 is treated as 1) and the mode.
// One-shot mode runs once and emits a single done pulse. Periodic mode emits
// a done pulse every N ticks until it is aborted or reset.
//
// Parameters:
//   CNT_W    width of n_clks and remaining
//   RETRIG   1 = start while running restarts the timer, 0 = ignored
//   PRESCALE clocks per count tick, used only when DELAY_TIMER_PRESCALE_EN
//            is defined (must be >= 1)
//
// Optional feature macro: DELAY_TIMER_PRESCALE_EN
//   When defined, a prescaler makes every count tick last PRESCALE edges.
//   When undefined, there is no prescaler and every edge is a tick.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   start     launches (or restarts) the timer
//   n_clks    delay length, latched with an accepted start
//   periodic  mode, latched with an accepted start (0 one-shot, 1 periodic)
//   abort     cancels a running timer
//   active    timer running and terminal count not yet reached
//   done      single-cycle terminal-count pulse
//   remaining ticks left until done
module delay_timer #(
  parameter int CNT_W    = 16,
  parameter int RETRIG   = 1,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] n_clks,
  input  logic             periodic,
  input  logic             abort,
  output logic             active,
  output logic             done,
  output logic [CNT_W-1:0] remaining
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] neff_lat;
  logic             per_lat;
  logic [CNT_W-1:0] neff_in;
  logic             running;
  logic             accept;
  logic             load_zero;
  logic             reload_zero;
  logic             at_zero;
  logic             last_edge;

  // A prescaler below 1 has no meaning; stop elaboration instead of
  // building a timer that never ticks.
  generate
    if (PRESCALE < 1) begin : g_bad_prescale
      $error("delay_timer: PRESCALE must be >= 1");
    end
  endgenerate

  // A requested length of zero behaves as a length of one.
  assign neff_in = (n_clks == '0) ? ONE : n_clks;
  assign running = (state == RUN);
  // Abort has priority over start while running; that case is handled
  // ahead of accept in the sequential block.
  assign accept  = start && (!running || (RETRIG != 0));

`ifdef DELAY_TIMER_PRESCALE_EN
  localparam int              PS_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_TOP = PS_W'(PRESCALE - 1);

  // The pair {remaining, sub} is a mixed-radix count of edges still to go:
  // remaining*PRESCALE + sub. Loading sub with PRESCALE-1 on start restarts
  // the prescaler phase, so done lands exactly N*PRESCALE-1 edges after the
  // start edge and remaining only moves on prescaler borrows (the ticks).
  logic [PS_W-1:0] sub;

  assign load_zero   = (neff_in == ONE) && (PRESCALE == 1);
  assign reload_zero = (neff_lat == ONE) && (PRESCALE == 1);
  assign at_zero     = (remaining == '0) && (sub == '0);
  assign last_edge   = (PRESCALE == 1) ? (remaining == ONE)
                                       : ((remaining == '0) && (sub == PS_W'(1)));
`else
  // Every edge is a tick: done fires on the edge that takes remaining to 0.
  assign load_zero   = (neff_in == ONE);
  assign reload_zero = (neff_lat == ONE);
  assign at_zero     = (remaining == '0);
  assign last_edge   = (remaining == ONE);
`endif

  // Main timer FSM. Priority per edge: reset, then abort of a running timer
  // (which also swallows a simultaneous start or terminal count), then an
  // accepted start (fresh or retrigger), then normal counting. All outputs
  // are registers so nothing combinational reaches the ports.
  // A one-shot run with a total length of one edge never enters RUN: the
  // start edge itself raises done and the FSM stays IDLE. Periodic runs sit
  // at zero for the done cycle and reload on the following edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      active    <= 1'b0;
      done      <= 1'b0;
      remaining <= '0;
      neff_lat  <= '0;
      per_lat   <= 1'b0;
`ifdef DELAY_TIMER_PRESCALE_EN
      sub       <= '0;
`endif
    end else if (running && abort) begin
      state     <= IDLE;
      active    <= 1'b0;
      done      <= 1'b0;
      remaining <= '0;
`ifdef DELAY_TIMER_PRESCALE_EN
      sub       <= '0;
`endif
    end else if (accept) begin
      neff_lat  <= neff_in;
      per_lat   <= periodic;
      remaining <= neff_in - ONE;
      done      <= load_zero;
`ifdef DELAY_TIMER_PRESCALE_EN
      sub       <= PS_TOP;
`endif
      if (periodic || !load_zero) begin
        state  <= RUN;
        active <= 1'b1;
      end else begin
        state  <= IDLE;
        active <= 1'b0;
      end
    end else if (running) begin
      if (at_zero) begin
        remaining <= neff_lat - ONE;
        done      <= reload_zero;
`ifdef DELAY_TIMER_PRESCALE_EN
        sub       <= PS_TOP;
`endif
      end else begin
`ifdef DELAY_TIMER_PRESCALE_EN
        if (sub == '0) begin
          sub       <= PS_TOP;
          remaining <= remaining - ONE;
        end else begin
          sub <= sub - PS_W'(1);
        end
`else
        remaining <= remaining - ONE;
`endif
        done <= last_edge;
        if (last_edge && !per_lat) begin
          state  <= IDLE;
          active <= 1'b0;
        end
      end
    end else begin
      done      <= 1'b0;
      active    <= 1'b0;
      remaining <= '0;
    end
  end

endmodule

// File: tb/tb_delay_timer.sv
// tb_delay_timer: self-checking bench for delay_timer.
//
// Two instances share all inputs: dut1 with RETRIG=1 and dut0 with RETRIG=0.
// A behavioural model derives every output from the edge distance to the
// accepted start edge and compares both instances on every falling edge.
// Directed sequences pin the model with hand-computed values, then a
// randomized run exercises mixed starts, aborts, resets and modes.
// Define DELAY_TIMER_PRESCALE_EN to build both design and bench with PRESCALE=4.
`timescale 1ns/1ps
module tb_delay_timer;

`ifdef DELAY_TIMER_PRESCALE_EN
  localparam int PS = 4;
`else
  localparam int PS = 1;
`endif
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         periodic = 1'b0;
  logic         abort = 1'b0;
  logic [W-1:0] nClks = '0;
  logic         act1, done1, act0, done0;
  logic [W-1:0] rem1, rem0;

  int     tests = 0;
  int     fails = 0;
  bit     checkEn = 1'b0;
  longint edgeNo = 0;

  // Model state, index 1 = retriggerable instance, index 0 = non-retriggerable.
  bit     mBusy[2];
  longint mE0[2];
  int     mNeff[2];
  bit     mPer[2];
  bit     expActive[2];
  bit     expDone[2];
  int     expRem[2];

  delay_timer #(.CNT_W(W), .RETRIG(1), .PRESCALE(PS)) dut1 (
    .clk(clk), .rst(rst), .start(start), .n_clks(nClks), .periodic(periodic),
    .abort(abort), .active(act1), .done(done1), .remaining(rem1)
  );

  delay_timer #(.CNT_W(W), .RETRIG(0), .PRESCALE(PS)) dut0 (
    .clk(clk), .rst(rst), .start(start), .n_clks(nClks), .periodic(periodic),
    .abort(abort), .active(act0), .done(done0), .remaining(rem0)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests++;
    if (actual != expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d (edge %0d)", name, actual, expected, edgeNo);
    end
  endtask

  // Behavioural model: a run is described only by its start edge, total
  // length (N*PS edges) and mode; outputs follow from the distance j to it.
  // "Running" before an edge is exactly what active showed in that cycle.
  task automatic modelStep();
    for (int i = 0; i < 2; i++) begin
      bit     running;
      longint j;
      longint total;
      longint m;
      running = expActive[i];
      if (rst) mBusy[i] = 1'b0;
      else if (running && abort) mBusy[i] = 1'b0;
      else if (start && (!running || i == 1)) begin
        mBusy[i] = 1'b1;
        mE0[i]   = edgeNo;
        mNeff[i] = (nClks == 0) ? 1 : int'(nClks);
        mPer[i]  = periodic;
      end
      expActive[i] = 1'b0;
      expDone[i]   = 1'b0;
      expRem[i]    = 0;
      if (mBusy[i]) begin
        total = longint'(mNeff[i]) * PS;
        j     = edgeNo - mE0[i];
        if (mPer[i]) begin
          m            = j % total;
          expActive[i] = 1'b1;
          expDone[i]   = (m == total - 1);
          expRem[i]    = int'((total - 1 - m) / PS);
        end else if (j < total - 1) begin
          expActive[i] = 1'b1;
          expRem[i]    = int'((total - 1 - j) / PS);
        end else if (j == total - 1) begin
          expDone[i] = 1'b1;
        end else begin
          mBusy[i] = 1'b0;
        end
      end
    end
    edgeNo++;
  endtask

  task automatic applyStimulus(input bit rs, input bit st, input int n, input bit pr, input bit ab);
    rst      = rs;
    start    = st;
    nClks    = W'(n);
    periodic = pr;
    abort    = ab;
    @(posedge clk);
    modelStep();
    #1;
  endtask

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("r1_active", int'(act1), int'(expActive[1]));
      checkOutput("r1_done", int'(done1), int'(expDone[1]));
      checkOutput("r1_remaining", int'(rem1), expRem[1]);
      checkOutput("r0_active", int'(act0), int'(expActive[0]));
      checkOutput("r0_done", int'(done0), int'(expDone[0]));
      checkOutput("r0_remaining", int'(rem0), expRem[0]);
    end
  end

  initial begin
    int doneAt;
    int actCnt;
    int cnt;
    int doneAt1;
    int doneAt0;
    int cnt1;
    int cnt0;
    int mask;
    int activeLate;

    for (int i = 0; i < 2; i++) begin
      mBusy[i] = 1'b0; mE0[i] = 0; mNeff[i] = 1; mPer[i] = 1'b0;
      expActive[i] = 1'b0; expDone[i] = 1'b0; expRem[i] = 0;
    end

    // Reset state.
    applyStimulus(1, 0, 0, 0, 0);
    checkEn = 1'b1;
    checkOutput("reset_active", int'(act1), 0);
    checkOutput("reset_done", int'(done1), 0);
    checkOutput("reset_remaining", int'(rem1), 0);
    applyStimulus(0, 0, 0, 0, 0);

    // One-shot N=100.
    applyStimulus(0, 1, 100, 0, 0);
    checkOutput("n100_rem_after_e0", int'(rem1), 99);
    checkOutput("n100_active_after_e0", int'(act1), 1);
    actCnt = 1;
    doneAt = -1;
    for (int k = 1; k <= 1000 && doneAt < 0; k++) begin
      applyStimulus(0, 0, 0, 0, 0);
      if (done1) begin
        doneAt = k;
        checkOutput("n100_active_in_done", int'(act1), 0);
        checkOutput("n100_rem_in_done", int'(rem1), 0);
      end else if (act1) begin
        actCnt++;
      end
    end
    checkOutput("n100_done_edge", doneAt, 100 * PS - 1);
    checkOutput("n100_active_cycles", actCnt, 100 * PS - 1);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("n100_done_width", int'(done1), 0);

`ifndef DELAY_TIMER_PRESCALE_EN
    // N=1 and N=0 one-shot: done right after the start edge, never active.
    for (int v = 1; v >= 0; v--) begin
      applyStimulus(0, 1, v, 0, 0);
      checkOutput("short_done", int'(done1), 1);
      checkOutput("short_active", int'(act1), 0);
      checkOutput("short_remaining", int'(rem1), 0);
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("short_done_clear", int'(done1), 0);
      checkOutput("short_active_clear", int'(act1), 0);
    end

    // Periodic N=5 with abort at edge E0+11.
    mask = 0;
    activeLate = 0;
    applyStimulus(0, 1, 5, 1, 0);
    if (done1) mask |= 1;
    for (int j = 1; j <= 20; j++) begin
      applyStimulus(0, 0, 0, 0, (j == 11));
      if (done1) mask |= (1 << j);
      if (j == 10) checkOutput("periodic_active_held", int'(act1), 1);
      if (j >= 11 && act1) activeLate++;
    end
    checkOutput("periodic_done_mask", mask, 528);
    checkOutput("periodic_active_after_abort", activeLate, 0);
`else
    // Prescaled one-shot N=3 with PRESCALE=4: done after edge E0+11.
    applyStimulus(0, 1, 3, 0, 0);
    doneAt = -1;
    for (int k = 1; k <= 100 && doneAt < 0; k++) begin
      applyStimulus(0, 0, 0, 0, 0);
      if (done1) doneAt = k;
    end
    checkOutput("prescale_done_edge", doneAt, 11);
`endif

    // Retrigger at E0+5 with N=3 after starting with N=10.
    applyStimulus(0, 0, 0, 0, 0);
    doneAt1 = -1; doneAt0 = -1; cnt1 = 0; cnt0 = 0;
    applyStimulus(0, 1, 10, 0, 0);
    for (int j = 1; j <= 10 * PS + 5; j++) begin
      applyStimulus(0, (j == 5), 3, 0, 0);
      if (done1) begin cnt1++; if (doneAt1 < 0) doneAt1 = j; end
      if (done0) begin cnt0++; if (doneAt0 < 0) doneAt0 = j; end
    end
    checkOutput("retrig1_done_edge", doneAt1, 5 + 3 * PS - 1);
    checkOutput("retrig1_done_count", cnt1, 1);
    checkOutput("retrig0_done_edge", doneAt0, 10 * PS - 1);
    checkOutput("retrig0_done_count", cnt0, 1);

    // Abort and start on the same edge while running: abort wins.
    applyStimulus(0, 1, 10, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 1, 4, 0, 1);
    checkOutput("abort_start_r1_active", int'(act1), 0);
    checkOutput("abort_start_r1_rem", int'(rem1), 0);
    checkOutput("abort_start_r0_active", int'(act0), 0);
    checkOutput("abort_start_r0_rem", int'(rem0), 0);
    cnt = 0;
    for (int j = 0; j < 15 * PS; j++) begin
      applyStimulus(0, 0, 0, 0, 0);
      if (done1 || done0) cnt++;
    end
    checkOutput("abort_start_no_done", cnt, 0);

    // Abort on the terminal-count edge suppresses done.
    cnt = 0;
    applyStimulus(0, 1, 4, 0, 0);
    for (int j = 1; j <= 4 * PS - 1; j++) begin
      applyStimulus(0, 0, 0, 0, (j == 4 * PS - 1));
      if (done1 || done0) cnt++;
    end
    checkOutput("abort_terminal_active", int'(act1), 0);
    for (int j = 0; j < 5; j++) begin
      applyStimulus(0, 0, 0, 0, 0);
      if (done1 || done0) cnt++;
    end
    checkOutput("abort_terminal_no_done", cnt, 0);

    // Reset at E0+50 of a 100-count run.
    applyStimulus(0, 1, 100, 0, 0);
    for (int j = 1; j < 50; j++) applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("midrun_rst_active", int'(act1), 0);
    checkOutput("midrun_rst_done", int'(done1), 0);
    checkOutput("midrun_rst_rem", int'(rem1), 0);
    cnt = 0;
    for (int j = 0; j < 200; j++) begin
      applyStimulus(0, 0, 0, 0, 0);
      if (done1 || done0) cnt++;
    end
    checkOutput("midrun_rst_no_done", cnt, 0);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      bit rs;
      bit st;
      bit pr;
      bit ab;
      int n;
      rs = ($urandom_range(0, 199) == 0);
      st = ($urandom_range(0, 7) == 0);
      pr = ($urandom_range(0, 2) == 0);
      ab = ($urandom_range(0, 19) == 0);
      n  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 60)) : int'($urandom_range(0, 8));
      if (st && ab && !(expActive[0] && expActive[1])) ab = 1'b0;
      applyStimulus(rs, st, n, pr, ab);
    end
    applyStimulus(0, 0, 0, 0, 0);

    checkEn = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
